stbc_system_top: RTL and testbench
==================================

# stbc_system_top

Fixed-point 4x4 MIMO detector top. It captures one complex channel matrix H (4x4) and one received block Y (4 rx x 2 slots) per frame. It then searches 16 transmit-column hypotheses for maximum matched-filter energy and hard-decides two Gray-coded 16-QAM symbols. It packs the hypothesis index and the two symbols into a 12-bit word with a one-cycle done strobe. It is the top of the decoder datapath, fed by the stimulus/ADC-side loader.

## Interface
- Q, 22, fractional bits of all signed fixed-point samples (1.0 = 2^Q)
- N, 32, sample width (two's complement)
- CLOCK_50 in 1 — sole clock, rising edge
- sys_rst in 1 — one clock; reset is asynchronous and active-low
- w_H_in_valid in 1 — H beat valid
- w_H_in_r / w_H_in_i in N — H element real/imag
- w_Y_in_valid in 1 — Y beat valid
- w_Y_in_r / w_Y_in_i in N — Y element real/imag
- w_decoder_done out 1 — one-cycle pulse, result valid
- w_signal_out_12bit out 12 — {q[3:0], sym1[3:0], sym2[3:0]}; held until next done

## Operation
- **LOAD**
  - H beats arrive row-major, H[r][c], beat k = 4r+c, 16 beats.
  - Y beats arrive row-major, Y[r][t], beat k = 2r+t, 8 beats.
  - Each stream has its own counter and is captured on valid=1. The two streams may interleave or overlap, and bubbles are allowed.
  - Beats arriving after a stream is complete are ignored until DONE.
- **ENERGY**: e[c] = Σ_r |H[r][c]|², c = 0..3.
- **CORR**: z[c][t] = Σ_r conj(H[r][c])·Y[r][t].
- **SEARCH**
  - For q = 0..15: a = q[3:2], b = q[1:0], M(q) = |z[a][0]|² + |z[b][1]|².
  - Keep the largest M; on a tie the lower q wins (strict >).
- **DECIDE**
  - sym1 is taken from z[a][0] with T = 2·e[a]. sym2 is taken from z[b][1] with T = 2·e[b].
  - Per axis x: x < −T → 00 (−3); −T ≤ x < 0 → 01 (−1); 0 ≤ x < T → 11 (+1); x ≥ T → 10 (+3).
  - Symbol nibble = {I bits, Q bits}.
- **Arithmetic**
  - Products are full 2N bits. Sums of four products are 2N+2 bits.
  - z and e are rescaled by >>Q and saturated to N bits (Q-format).
  - |z|² is computed at 2N bits, then >>Q.
  - M is accumulated at N+2 bits, unsigned.
- **DONE**
  - Asserts w_decoder_done for 1 cycle and updates the output register.
  - Clears both load counters and returns to LOAD. H and Y are reloaded every frame.

## Timing
- **Reset values**: w_decoder_done = 0, w_signal_out_12bit = 0, FSM = LOAD, counters = 0, stored H/Y/z/e = 0.
- **State sequence**: LOAD → ENERGY (16 cycles, one complex MAC/cycle) → CORR (32) → SEARCH (16) → DECIDE (1) → DONE (1).
- **Leaving LOAD**: happens on the edge after the cycle in which the last outstanding beat (H or Y) is sampled.
- **Latency**: w_decoder_done is high in exactly the 67th cycle after that final-beat cycle. Fixed latency, independent of data.
- **Input ready**: beats presented outside LOAD are dropped, with no back-pressure. The source must wait for done before starting the next frame's beats.
- **Reset mid-frame**: reset asserted in any state aborts the frame immediately (async). No done pulse is produced.

## Structure
- **Shared package** `stbc_pkg`:
  - Q, N.
  - Complex sample struct {re, im}.
  - FSM state enum.
  - Gray-code constants 00/01/11/10.
  - Candidate decode function q → (a, b).
- **Sub-module** `cmac`:
  - Natural single sub-module: one complex multiply-accumulate with conjugate option.
  - Shared by ENERGY and CORR.
  - Includes the >>Q saturating rescale.
- **Top**: FSM, H/Y register files, z/e storage, search comparator, slicer.

## Test plan
- **Identity channel, hypothesis 6**
  - Stimulus: H = I (diag 0x00400000), Y[1][0] = 3+1j (0x00C00000, 0x00400000), Y[2][1] = −1−3j, all other Y elements 0.
  - Required: done once, output 0x6B4 (q=6, sym1=1011, sym2=0100).
- **Zero Y**
  - Stimulus: H = I, Y = 0.
  - Required: all metrics tie, q=0, output 0x0FF.
- **Ten back-to-back frames**
  - Stimulus: same H each frame, with the identity-channel Y cycled through q = 0..9 and 16-QAM points.
  - Required: each done arrives exactly 67 cycles after the last beat. Outputs match the golden model bit-exactly.
- **Interleaved and gapped loading**
  - Stimulus: Y finishes before H; random valid bubbles on both streams; extra beats sent after completion.
  - Required: result identical to a gapless load; extra beats ignored.
- **Reset mid-operation**
  - Stimulus: sys_rst pulsed low during CORR.
  - Required: outputs are 0 with no done pulse. The next full frame decodes correctly.
- **Saturation**
  - Stimulus: H and Y at near full-scale (0x7FFFFFFF).
  - Required: z and e saturate without wrap. The slicer returns +3/+3 (nibble 1010) for positive data.

Source files
------------

// File: rtl/stbc_pkg.sv
// Shared types, constants and arithmetic helpers for the 4x4 MIMO detector.
// Fixed-point samples are signed Q-format with Q fractional bits.
package stbc_pkg;

   localparam int Q     = 22;
   localparam int N     = 32;
   localparam int P_W   = 2 * N;
   localparam int ACC_W = 2 * N + 3;
   localparam int M_W   = N + 2;

   typedef struct packed {
      logic signed [N-1:0] re;
      logic signed [N-1:0] im;
   } cplx_t;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_ENERGY,
      ST_CORR,
      ST_SEARCH,
      ST_DECIDE,
      ST_DONE
   } state_t;

   localparam logic [1:0] GRAY_M3 = 2'b00;
   localparam logic [1:0] GRAY_M1 = 2'b01;
   localparam logic [1:0] GRAY_P1 = 2'b11;
   localparam logic [1:0] GRAY_P3 = 2'b10;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
   } cand_t;

   function automatic cand_t cand_decode(input logic [3:0] q);
      cand_t c;
      c.a = q[3:2];
      c.b = q[1:0];
      return c;
   endfunction

   // Arithmetic shift back to Q-format, clamping instead of wrapping.
   function automatic logic signed [N-1:0] sat_rescale(input logic signed [ACC_W-1:0] x);
      logic signed [ACC_W-1:0] s;
      s = x >>> Q;
      if ((&s[ACC_W-1:N-1]) || !(|s[ACC_W-1:N-1]))
         return s[N-1:0];
      else if (s[ACC_W-1])
         return {1'b1, {(N-1){1'b0}}};
      else
         return {1'b0, {(N-1){1'b1}}};
   endfunction

   // |z|^2 >> Q, clamped to N+1 unsigned bits so the N+2 bit metric cannot wrap.
   function automatic logic [N:0] mag_q(input cplx_t z);
      logic signed [P_W-1:0] xr;
      logic signed [P_W-1:0] xi;
      logic [P_W-1:0]        s;
      xr = {{N{z.re[N-1]}}, z.re};
      xi = {{N{z.im[N-1]}}, z.im};
      s  = xr * xr + xi * xi;
      if (|s[P_W-1:N+Q+1])
         return '1;
      else
         return s[N+Q:Q];
   endfunction

   function automatic logic [1:0] slice_axis(input logic signed [N-1:0] x,
                                             input logic signed [N-1:0] e);
      logic signed [N+1:0] xx;
      logic signed [N+1:0] tt;
      xx = {{2{x[N-1]}}, x};
      tt = {e[N-1], e, 1'b0};
      if (xx < -tt)
         return GRAY_M3;
      else if (xx[N+1])
         return GRAY_M1;
      else if (xx < tt)
         return GRAY_P1;
      else
         return GRAY_P3;
   endfunction

endpackage

// File: rtl/stbc_cmac.sv
// Complex multiply-accumulate with optional conjugate on operand a.
// o_sum is the running sum including this cycle's product, rescaled and saturated.
module cmac
   import stbc_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_en,
   input  logic                i_first,
   input  logic                i_conj,
   input  logic signed [N-1:0] i_a_re,
   input  logic signed [N-1:0] i_a_im,
   input  logic signed [N-1:0] i_b_re,
   input  logic signed [N-1:0] i_b_im,
   output logic signed [N-1:0] o_sum_re,
   output logic signed [N-1:0] o_sum_im
);

   logic signed [P_W-1:0]   w_ar, w_ai, w_br, w_bi;
   logic signed [P_W-1:0]   w_rr, w_ii, w_ri, w_ir;
   logic signed [ACC_W-1:0] w_rr_x, w_ii_x, w_ri_x, w_ir_x;
   logic signed [ACC_W-1:0] w_term_re, w_term_im;
   logic signed [ACC_W-1:0] w_sum_re, w_sum_im;
   logic signed [ACC_W-1:0] r_acc_re, r_acc_im;

   assign w_ar = {{N{i_a_re[N-1]}}, i_a_re};
   assign w_ai = {{N{i_a_im[N-1]}}, i_a_im};
   assign w_br = {{N{i_b_re[N-1]}}, i_b_re};
   assign w_bi = {{N{i_b_im[N-1]}}, i_b_im};

   assign w_rr = w_ar * w_br;
   assign w_ii = w_ai * w_bi;
   assign w_ri = w_ar * w_bi;
   assign w_ir = w_ai * w_br;

   assign w_rr_x = {{(ACC_W-P_W){w_rr[P_W-1]}}, w_rr};
   assign w_ii_x = {{(ACC_W-P_W){w_ii[P_W-1]}}, w_ii};
   assign w_ri_x = {{(ACC_W-P_W){w_ri[P_W-1]}}, w_ri};
   assign w_ir_x = {{(ACC_W-P_W){w_ir[P_W-1]}}, w_ir};

   // conj(a)*b flips the sign of every a.im contribution.
   assign w_term_re = i_conj ? (w_rr_x + w_ii_x) : (w_rr_x - w_ii_x);
   assign w_term_im = i_conj ? (w_ri_x - w_ir_x) : (w_ri_x + w_ir_x);

   assign w_sum_re = (i_first ? '0 : r_acc_re) + w_term_re;
   assign w_sum_im = (i_first ? '0 : r_acc_im) + w_term_im;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_re <= '0;
         r_acc_im <= '0;
      end else if (i_en) begin
         r_acc_re <= w_sum_re;
         r_acc_im <= w_sum_im;
      end
   end

   assign o_sum_re = sat_rescale(w_sum_re);
   assign o_sum_im = sat_rescale(w_sum_im);

endmodule

// File: rtl/stbc_system_top.sv
// 4x4 MIMO detector: load H/Y, energy + matched-filter correlation on a shared
// CMAC, 16-hypothesis max-energy search, Gray 16-QAM slicing, 12-bit result.
module stbc_system_top
   import stbc_pkg::*;
(
   input  logic          CLOCK_50,
   input  logic          sys_rst,
   input  logic          w_H_in_valid,
   input  logic [N-1:0]  w_H_in_r,
   input  logic [N-1:0]  w_H_in_i,
   input  logic          w_Y_in_valid,
   input  logic [N-1:0]  w_Y_in_r,
   input  logic [N-1:0]  w_Y_in_i,
   output logic          w_decoder_done,
   output logic [11:0]   w_signal_out_12bit
);

   state_t              r_state, w_state_nxt;
   logic [4:0]          r_cnt;
   logic [4:0]          r_hcnt;
   logic [3:0]          r_ycnt;
   cplx_t               r_h [16];
   cplx_t               r_y [8];
   cplx_t               r_z [8];
   logic signed [N-1:0] r_e [4];
   logic [M_W-1:0]      r_best_m;
   logic [3:0]          r_best_q;
   logic [3:0]          r_sym1, r_sym2;
   logic [11:0]         r_out;
   logic                r_done;

   logic                w_h_cap, w_y_cap, w_h_full, w_y_full;
   logic [1:0]          w_row, w_col;
   logic                w_slot;
   cplx_t               w_mac_a, w_mac_b;
   logic                w_mac_en, w_mac_first;
   logic signed [N-1:0] w_mac_re, w_mac_im;
   cand_t               w_cand, w_best;
   logic [M_W-1:0]      w_m;
   cplx_t               w_za, w_zb;

   assign w_h_cap  = (r_state == ST_LOAD) && w_H_in_valid && (r_hcnt != 5'd16);
   assign w_y_cap  = (r_state == ST_LOAD) && w_Y_in_valid && (r_ycnt != 4'd8);
   assign w_h_full = (r_hcnt == 5'd16) || (w_h_cap && r_hcnt == 5'd15);
   assign w_y_full = (r_ycnt == 4'd8) || (w_y_cap && r_ycnt == 4'd7);

   always_ff @(posedge CLOCK_50 or negedge sys_rst) begin
      if (!sys_rst) r_state <= ST_LOAD;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_LOAD:   if (w_h_full && w_y_full) w_state_nxt = ST_ENERGY;
         ST_ENERGY: if (r_cnt == 5'd15)       w_state_nxt = ST_CORR;
         ST_CORR:   if (r_cnt == 5'd31)       w_state_nxt = ST_SEARCH;
         ST_SEARCH: if (r_cnt == 5'd15)       w_state_nxt = ST_DECIDE;
         ST_DECIDE:                           w_state_nxt = ST_DONE;
         ST_DONE:                             w_state_nxt = ST_LOAD;
         default:                             w_state_nxt = ST_LOAD;
      endcase
   end

   // ENERGY walks (col,row) over H; CORR walks (col,slot,row), rows innermost.
   always_comb begin
      w_row       = r_cnt[1:0];
      w_col       = (r_state == ST_CORR) ? r_cnt[4:3] : r_cnt[3:2];
      w_slot      = r_cnt[2];
      w_mac_a     = r_h[{w_row, w_col}];
      w_mac_b     = (r_state == ST_CORR) ? r_y[{w_row, w_slot}] : w_mac_a;
      w_mac_en    = (r_state == ST_ENERGY) || (r_state == ST_CORR);
      w_mac_first = (w_row == 2'd0);
   end

   cmac u_cmac (
      .clk      (CLOCK_50),
      .rst_n    (sys_rst),
      .i_en     (w_mac_en),
      .i_first  (w_mac_first),
      .i_conj   (1'b1),
      .i_a_re   (w_mac_a.re),
      .i_a_im   (w_mac_a.im),
      .i_b_re   (w_mac_b.re),
      .i_b_im   (w_mac_b.im),
      .o_sum_re (w_mac_re),
      .o_sum_im (w_mac_im)
   );

   assign w_cand = cand_decode(r_cnt[3:0]);
   assign w_best = cand_decode(r_best_q);
   assign w_m    = {1'b0, mag_q(r_z[{w_cand.a, 1'b0}])} + {1'b0, mag_q(r_z[{w_cand.b, 1'b1}])};
   assign w_za   = r_z[{w_best.a, 1'b0}];
   assign w_zb   = r_z[{w_best.b, 1'b1}];

   always_ff @(posedge CLOCK_50 or negedge sys_rst) begin
      if (!sys_rst) begin
         r_cnt    <= '0;
         r_hcnt   <= '0;
         r_ycnt   <= '0;
         r_best_m <= '0;
         r_best_q <= '0;
         r_sym1   <= '0;
         r_sym2   <= '0;
         r_out    <= '0;
         r_done   <= 1'b0;
         for (int i = 0; i < 16; i++) r_h[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            r_y[i] <= '0;
            r_z[i] <= '0;
         end
         for (int i = 0; i < 4; i++) r_e[i] <= '0;
      end else begin
         r_done <= (r_state == ST_DONE);

         if (w_state_nxt != r_state)
            r_cnt <= '0;
         else if (w_mac_en || r_state == ST_SEARCH)
            r_cnt <= r_cnt + 5'd1;

         if (r_state == ST_DONE) begin
            r_hcnt <= '0;
            r_ycnt <= '0;
            r_out  <= {r_best_q, r_sym1, r_sym2};
         end else begin
            if (w_h_cap) begin
               r_h[r_hcnt[3:0]] <= {w_H_in_r, w_H_in_i};
               r_hcnt           <= r_hcnt + 5'd1;
            end
            if (w_y_cap) begin
               r_y[r_ycnt[2:0]] <= {w_Y_in_r, w_Y_in_i};
               r_ycnt           <= r_ycnt + 4'd1;
            end
         end

         // The last row of each column closes a sum; store it straight from the MAC.
         if (r_state == ST_ENERGY && w_row == 2'd3)
            r_e[w_col] <= w_mac_re;
         if (r_state == ST_CORR && w_row == 2'd3)
            r_z[{w_col, w_slot}] <= {w_mac_re, w_mac_im};

         if (r_state == ST_SEARCH && (r_cnt == 5'd0 || w_m > r_best_m)) begin
            r_best_m <= w_m;
            r_best_q <= r_cnt[3:0];
         end

         if (r_state == ST_DECIDE) begin
            r_sym1 <= {slice_axis(w_za.re, r_e[w_best.a]), slice_axis(w_za.im, r_e[w_best.a])};
            r_sym2 <= {slice_axis(w_zb.re, r_e[w_best.b]), slice_axis(w_zb.im, r_e[w_best.b])};
         end
      end
   end

   assign w_decoder_done     = r_done;
   assign w_signal_out_12bit = r_out;

endmodule

// File: tb/tb_stbc_system_top.sv
// Directed bench for stbc_system_top: hand-computed 12-bit results, latency,
// load ordering, mid-frame reset and saturation corners.
module tb_stbc_system_top;

   logic        CLOCK_50;
   logic        sys_rst;
   logic        w_H_in_valid;
   logic [31:0] w_H_in_r, w_H_in_i;
   logic        w_Y_in_valid;
   logic [31:0] w_Y_in_r, w_Y_in_i;
   logic        w_decoder_done;
   logic [11:0] w_signal_out_12bit;

   logic [31:0] th_r [16];
   logic [31:0] th_i [16];
   logic [31:0] ty_r [8];
   logic [31:0] ty_i [8];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int t_last = 0;

   int         lv [4] = '{-3, -1, 1, 3};
   logic [1:0] gc [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   stbc_system_top dut (
      .CLOCK_50           (CLOCK_50),
      .sys_rst            (sys_rst),
      .w_H_in_valid       (w_H_in_valid),
      .w_H_in_r           (w_H_in_r),
      .w_H_in_i           (w_H_in_i),
      .w_Y_in_valid       (w_Y_in_valid),
      .w_Y_in_r           (w_Y_in_r),
      .w_Y_in_i           (w_Y_in_i),
      .w_decoder_done     (w_decoder_done),
      .w_signal_out_12bit (w_signal_out_12bit)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fx(input int l);
      return 32'(l * 4194304);
   endfunction

   task automatic set_h_all(input logic [31:0] re, input logic [31:0] diag_only);
      for (int k = 0; k < 16; k++) begin
         th_r[k] = (diag_only != 0 && (k / 4) != (k % 4)) ? 32'h0 : re;
         th_i[k] = 32'h0;
      end
   endtask

   task automatic set_y_all(input logic [31:0] re, input logic [31:0] im);
      for (int k = 0; k < 8; k++) begin
         ty_r[k] = re;
         ty_i[k] = im;
      end
   endtask

   task automatic set_y(input int r, input int t, input logic [31:0] re, input logic [31:0] im);
      ty_r[2*r+t] = re;
      ty_i[2*r+t] = im;
   endtask

   // mode 0: H and Y side by side, no gaps. mode 1: Y first, random bubbles,
   // stray beats after each stream completes.
   task automatic send_frame(input int mode);
      int hk, yk;
      hk = 0;
      yk = 0;
      if (mode == 0) begin
         for (int k = 0; k < 16; k++) begin
            @(negedge CLOCK_50);
            w_H_in_valid = 1'b1; w_H_in_r = th_r[k]; w_H_in_i = th_i[k];
            w_Y_in_valid = (k < 8);
            if (k < 8) begin w_Y_in_r = ty_r[k]; w_Y_in_i = ty_i[k]; end
            t_last = cyc;
         end
      end else begin
         while (yk < 8) begin
            @(negedge CLOCK_50);
            w_H_in_valid = 1'b0;
            w_Y_in_valid = 1'b0;
            if ($urandom_range(0, 2) != 0) begin
               w_Y_in_valid = 1'b1; w_Y_in_r = ty_r[yk]; w_Y_in_i = ty_i[yk];
               yk++;
            end
         end
         while (hk < 16) begin
            @(negedge CLOCK_50);
            w_Y_in_valid = 1'b1; w_Y_in_r = $urandom; w_Y_in_i = $urandom;
            w_H_in_valid = 1'b0;
            if ($urandom_range(0, 2) != 0) begin
               w_H_in_valid = 1'b1; w_H_in_r = th_r[hk]; w_H_in_i = th_i[hk];
               hk++;
               t_last = cyc;
            end
         end
         for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK_50);
            w_H_in_valid = 1'b1; w_H_in_r = $urandom; w_H_in_i = $urandom;
         end
      end
      @(negedge CLOCK_50);
      w_H_in_valid = 1'b0;
      w_Y_in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [11:0] exp);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge CLOCK_50);
         if (w_decoder_done) seen = 1'b1;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_lat"}, 32'(cyc - t_last), 32'd67);
         chk({tag, "_out"}, 32'(w_signal_out_12bit), 32'(exp));
         @(negedge CLOCK_50);
         chk({tag, "_pulse"}, 32'(w_decoder_done), 32'd0);
         chk({tag, "_hold"}, 32'(w_signal_out_12bit), 32'(exp));
      end
   endtask

   initial begin
      int pulses;
      logic [11:0] exp;
      sys_rst = 1'b0;
      w_H_in_valid = 1'b0; w_H_in_r = '0; w_H_in_i = '0;
      w_Y_in_valid = 1'b0; w_Y_in_r = '0; w_Y_in_i = '0;
      repeat (3) @(negedge CLOCK_50);
      chk("reset_done", 32'(w_decoder_done), 32'd0);
      chk("reset_out", 32'(w_signal_out_12bit), 32'd0);
      sys_rst = 1'b1;
      @(negedge CLOCK_50);

      // Identity channel: z = Y, best pair (a=1,b=2) -> q=6.
      set_h_all(fx(1), 1);
      set_y_all(32'h0, 32'h0);
      set_y(1, 0, fx(3), fx(1));
      set_y(2, 1, fx(-1), fx(-3));
      send_frame(0);
      wait_done("ident", 12'h6B4);

      set_y_all(32'h0, 32'h0);
      send_frame(0);
      wait_done("zero", 12'h0FF);

      for (int i = 0; i < 10; i++) begin
         logic [3:0] q4;
         q4 = 4'(i);
         set_y_all(32'h0, 32'h0);
         set_y(i / 4, 0, fx(lv[i % 4]), fx(lv[(i + 1) % 4]));
         set_y(i % 4, 1, fx(lv[(i + 2) % 4]), fx(lv[(i + 3) % 4]));
         exp = {q4, gc[i % 4], gc[(i + 1) % 4], gc[(i + 2) % 4], gc[(i + 3) % 4]};
         send_frame(0);
         wait_done($sformatf("b2b%0d", i), exp);
      end

      // Slicer thresholds at exactly +/-T and one ulp beyond.
      set_y_all(32'h0, 32'h0);
      set_y(0, 0, 32'h0080_0000, 32'hFF80_0000);
      set_y(3, 1, 32'h0, fx(-1));
      send_frame(0);
      wait_done("edge_eq", 12'h39D);

      set_y_all(32'h0, 32'h0);
      set_y(1, 0, 32'hFF7F_FFFF, 32'h007F_FFFF);
      set_y(2, 1, 32'h0, fx(1));
      send_frame(0);
      wait_done("edge_ulp", 12'h63F);

      set_y_all(32'h0, 32'h0);
      set_y(1, 0, fx(3), fx(1));
      set_y(2, 1, fx(-1), fx(-3));
      send_frame(1);
      wait_done("gapped", 12'h6B4);

      // Reset while correlating must abort silently.
      set_y_all(32'h0, 32'h0);
      send_frame(0);
      repeat (25) @(negedge CLOCK_50);
      sys_rst = 1'b0;
      #1;
      chk("rst_done", 32'(w_decoder_done), 32'd0);
      chk("rst_out", 32'(w_signal_out_12bit), 32'd0);
      @(negedge CLOCK_50);
      sys_rst = 1'b1;
      pulses = 0;
      for (int n = 0; n < 120; n++) begin
         @(negedge CLOCK_50);
         if (w_decoder_done) pulses++;
      end
      chk("rst_nodone", 32'(pulses), 32'd0);
      chk("rst_out_hold", 32'(w_signal_out_12bit), 32'd0);
      set_y(1, 0, fx(3), fx(1));
      set_y(2, 1, fx(-1), fx(-3));
      send_frame(0);
      wait_done("post_rst", 12'h6B4);

      // z clamps at +max while e stays small: +3/+3 on both symbols.
      set_h_all(fx(1), 0);
      set_y_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      send_frame(0);
      wait_done("sat_z", 12'h0AA);

      // Both z and e clamp: T = 2*max exceeds z, so +1/+1.
      set_h_all(32'h7FFF_FFFF, 0);
      send_frame(0);
      wait_done("sat_ze", 12'h0FF);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
